sap_control_sequencer: RTL
==========================

Name: sap_control_sequencer

Overview:
Microcoded control sequencer for the 8-bit bus machine. It steps a one-hot T-state ring, decodes the instruction-register opcode, and drives the active-low bus enables and load strobes for the PC, MAR, 16x8 program/data memory, IR, A, B, ALU and OUT registers. It also owns the halt latch and the run/single-step gating. Its mem_out_n output drives the memory's low-active output enable directly.

Parameters:
EARLY_END, 1, 1 = an instruction returns to T1 after its last active T-state; 0 = every non-halt instruction takes all 6 T-states
OPC_LDA, 4'h0, opcode: load A from memory
OPC_SUB, 4'h1, opcode: A = A - mem
OPC_ADD, 4'h2, opcode: A = A + mem
OPC_OUT, 4'he, opcode: OUT = A
OPC_HLT, 4'hf, opcode: halt

Ports:
clk  in  1  single system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  4  IR[7:4]
run  in  1  1 = free-run; 0 = advance only on step
step  in  1  single-cycle pulse; advances one T-state when run=0
tstate  out  6  one-hot T1..T6 (bit0 = T1)
halted  out  1  halt latch
pc_inc  out  1  PC increment, active-high
pc_out_n  out  1  PC onto bus
mar_load_n  out  1  MAR load
mem_out_n  out  1  memory onto bus
ir_load_n  out  1  IR load
ir_out_n  out  1  IR[3:0] onto bus
a_load_n  out  1  A load
a_out_n  out  1  A onto bus
b_load_n  out  1  B load
alu_out_n  out  1  ALU result onto bus
alu_sub  out  1  1 = subtract
out_load_n  out  1  OUT register load

Behaviour:
- Reset: synchronous. Clock is clk, reset is rst, active-high. While rst=1 at a rising edge: tstate=6'b000001, halted=0. While rst is high, all _n outputs = 1, and pc_inc and alu_sub = 0 (gated combinationally by rst). Reset mid-instruction aborts it with no partial strobes afterwards.
- Advance enable: adv = !halted & (run | step). If adv=0, tstate holds.
- Control outputs are a combinational decode of tstate and opcode (Moore). If adv=0 or halted=1, every strobe is inactive, so no load repeats while paused. Bus enables and loads are only valid in advancing cycles.
- T1: pc_out_n=0, mar_load_n=0.
- T2: pc_inc=1.
- T3: mem_out_n=0, ir_load_n=0.
- T4 behaviour by opcode:
  - LDA/ADD/SUB: ir_out_n=0, mar_load_n=0.
  - OUT: a_out_n=0, out_load_n=0.
  - HLT: no strobes; halted is set at the end of this cycle.
  - Others (NOP): none.
- T5 behaviour by opcode:
  - LDA: mem_out_n=0, a_load_n=0.
  - ADD/SUB: mem_out_n=0, b_load_n=0.
  - Others: none.
- T6 behaviour by opcode:
  - ADD: alu_out_n=0, a_load_n=0, alu_sub=0.
  - SUB: same, with alu_sub=1.
  - Others: none.
- Next state when adv=1:
  - T6 goes to T1.
  - With EARLY_END=1: OUT/NOP go T4 to T1; LDA goes T5 to T1.
  - With EARLY_END=0: always advance to the next T-state up to T6.
- Halt: when T4 with opcode==OPC_HLT and adv=1, halted becomes 1 and tstate holds at T4. Only rst clears halted; run and step are ignored while halted.
- opcode is sampled each cycle, valid from T4 onward (IR loaded at end of T3). Changes to opcode during T1–T3 have no effect.
- tstate is always exactly one-hot. An illegal encoding (not reachable) recovers to T1 on the next advance.
- Simultaneous run=1 and step=1: advance once, same as run alone.

Test Plan:
- Reset then run=1, memory program {08,19,ee,ff}, EARLY_END=1 -> T-state counts per instruction are LDA 5, SUB 6, OUT 4, HLT 4. halted=1 after the 19th rising edge following reset release, and tstate stays 6'b001000.
- Same program, EARLY_END=0 -> halted=1 after the 22nd edge. Strobes in unused T-states (LDA T6, OUT T5/T6) are all inactive.
- SUB instruction (opcode=1) -> T6 has alu_out_n=0, a_load_n=0, alu_sub=1. ADD (opcode=2) gives the same T6 with alu_sub=0. T5 has mem_out_n=0, b_load_n=0 for both.
- run=0, step pulsed every 3rd cycle -> tstate advances exactly once per pulse. All strobes are inactive in non-step cycles; a step in T3 produces exactly one ir_load_n low cycle.
- rst asserted in T5 of LDA -> on the next edge tstate=T1 and halted=0. All strobes are inactive during rst, and T1 strobes appear in the first cycle after release.
- Halted machine with run=1, step=1, opcode changing -> tstate, halted and all strobes stay constant until rst. After rst, the machine refetches from T1.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// Purpose: T-state ring, opcode decode and bus strobes for the 8-bit bus machine, plus halt latch and run/step gating.
// Latency: strobes decode combinationally from the current T-state; tstate/halted update on the clock edge that ends an advancing cycle.
// Backpressure: run=0 stalls the ring until a step pulse; all strobes stay inactive in stalled, halted or reset cycles.
module sap_control_sequencer #(
  parameter bit         EARLY_END = 1'b1,
  parameter logic [3:0] OPC_LDA   = 4'h0,
  parameter logic [3:0] OPC_SUB   = 4'h1,
  parameter logic [3:0] OPC_ADD   = 4'h2,
  parameter logic [3:0] OPC_OUT   = 4'he,
  parameter logic [3:0] OPC_HLT   = 4'hf
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       run,
  input  logic       step,
  output logic [5:0] tstate,
  output logic       halted,
  output logic       pc_inc,
  output logic       pc_out_n,
  output logic       mar_load_n,
  output logic       mem_out_n,
  output logic       ir_load_n,
  output logic       ir_out_n,
  output logic       a_load_n,
  output logic       a_out_n,
  output logic       b_load_n,
  output logic       alu_out_n,
  output logic       alu_sub,
  output logic       out_load_n
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state_q;

  logic adv;
  logic fire;
  logic is_lda;
  logic is_sub;
  logic is_add;
  logic is_out;
  logic is_hlt;
  logic is_mem_op;

  // A cycle advances only when not halted and either free-running or stepped.
  assign adv  = !halted && (run || step);
  // Strobes additionally need reset low so an aborted instruction leaves nothing behind.
  assign fire = adv && !rst;

  assign is_lda    = (opcode == OPC_LDA);
  assign is_sub    = (opcode == OPC_SUB);
  assign is_add    = (opcode == OPC_ADD);
  assign is_out    = (opcode == OPC_OUT);
  assign is_hlt    = (opcode == OPC_HLT);
  assign is_mem_op = is_lda || is_sub || is_add;

  assign tstate = state_q;

  // T-state ring and halt latch; opcode only steers transitions from T4 onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T1;
      halted  <= 1'b0;
    end else if (adv) begin
      case (state_q)
        T1: state_q <= T2;
        T2: state_q <= T3;
        T3: state_q <= T4;
        T4: begin
          if (is_hlt) begin
            halted <= 1'b1;
          end else if (EARLY_END && !is_mem_op) begin
            state_q <= T1;
          end else begin
            state_q <= T5;
          end
        end
        T5: begin
          if (EARLY_END && is_lda) begin
            state_q <= T1;
          end else begin
            state_q <= T6;
          end
        end
        T6:      state_q <= T1;
        default: state_q <= T1;
      endcase
    end
  end

  // Moore decode of T-state and opcode into bus enables and load strobes.
  always_comb begin
    pc_inc     = 1'b0;
    pc_out_n   = 1'b1;
    mar_load_n = 1'b1;
    mem_out_n  = 1'b1;
    ir_load_n  = 1'b1;
    ir_out_n   = 1'b1;
    a_load_n   = 1'b1;
    a_out_n    = 1'b1;
    b_load_n   = 1'b1;
    alu_out_n  = 1'b1;
    alu_sub    = 1'b0;
    out_load_n = 1'b1;
    if (fire) begin
      case (state_q)
        T1: begin
          pc_out_n   = 1'b0;
          mar_load_n = 1'b0;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          mem_out_n = 1'b0;
          ir_load_n = 1'b0;
        end
        T4: begin
          if (is_mem_op) begin
            ir_out_n   = 1'b0;
            mar_load_n = 1'b0;
          end else if (is_out) begin
            a_out_n    = 1'b0;
            out_load_n = 1'b0;
          end
        end
        T5: begin
          if (is_lda) begin
            mem_out_n = 1'b0;
            a_load_n  = 1'b0;
          end else if (is_add || is_sub) begin
            mem_out_n = 1'b0;
            b_load_n  = 1'b0;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            alu_out_n = 1'b0;
            a_load_n  = 1'b0;
            alu_sub   = is_sub;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
